// File: rtl/key_matrix_scan_pkg.sv
// key_pkg: shared keypad constants, key code type and bit-vector helpers.
package key_pkg;
    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    typedef logic [3:0] key_code_t;

    function automatic key_code_t onehot16_to_code(input logic [15:0] v);
        key_code_t c;
        c = '0;
        for (int i = 0; i < 16; i++) c = v[i] ? 4'(i) : c;
        return c;
    endfunction

    function automatic logic popcount_is_one(input logic [15:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction
endpackage

// File: rtl/key_matrix_scan_if.sv
// key_matrix_scan_if: keypad pins plus committed key event outputs.
interface key_matrix_scan_if;
    import key_pkg::*;
    logic [3:0] key_col;
    logic [3:0] key_row;
    key_code_t  key_code;
    logic       key_valid;
    logic       key_down;
    modport master (input key_col, output key_row, key_code, key_valid, key_down);
    modport slave  (output key_col, input key_row, key_code, key_valid, key_down);
endinterface

// File: rtl/key_matrix_scan_tick.sv
// scan_tick_gen: free-running dwell counter, tick on its terminal count.
module scan_tick_gen #(
    parameter int unsigned SCAN_TICK = 50_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tick
);
    localparam int W = $clog2(SCAN_TICK);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = cnt_q == W'(SCAN_TICK - 1);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x4 keypad row scanner with frame-level debounce and press events.
module key_matrix_scan
    import key_pkg::*;
#(
    parameter int unsigned SCAN_TICK    = 50_000,
    parameter int unsigned DEBOUNCE_CNT = 20
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    key_matrix_scan_if.master  kif
);
    localparam int SW = $clog2(DEBOUNCE_CNT + 1);

    logic            tick, frame_end, same, commit;
    logic [1:0]      row_q, row_d;
    logic [15:0]     snap_q, snap_d, last_q, last_d, state_q, state_d;
    logic [SW-1:0]   stable_q, stable_d;
    key_code_t       code_q, code_d;
    logic            valid_q, valid_d, down_q, down_d;

    scan_tick_gen #(.SCAN_TICK(SCAN_TICK)) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tick    (tick)
    );

    always_comb begin
        snap_d = snap_q;
        if (tick) snap_d[{row_q, 2'b00} +: 4] = ~kif.key_col;
        row_d     = row_q + 2'(tick);
        frame_end = tick && (row_q == 2'd3);
        same      = snap_d == last_q;
        // Commit only on the frame that completes the stable window.
        commit    = frame_end && same && (stable_q == SW'(DEBOUNCE_CNT - 1)) && (last_q != state_q);
        last_d    = (frame_end && !same) ? snap_d : last_q;
        stable_d  = !frame_end ? stable_q :
                    !same ? '0 :
                    (stable_q == SW'(DEBOUNCE_CNT)) ? stable_q : stable_q + 1'b1;
        state_d   = commit ? last_q : state_q;
        valid_d   = commit && popcount_is_one(last_q) && (state_q == '0);
        code_d    = valid_d ? onehot16_to_code(last_q) : code_q;
        down_d    = |state_d;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            row_q    <= '0;
            snap_q   <= '0;
            last_q   <= '0;
            state_q  <= '0;
            stable_q <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            down_q   <= 1'b0;
        end else begin
            row_q    <= row_d;
            snap_q   <= snap_d;
            last_q   <= last_d;
            state_q  <= state_d;
            stable_q <= stable_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            down_q   <= down_d;
        end
    end

    assign kif.key_row   = ~(4'b0001 << row_q);
    assign kif.key_code  = code_q;
    assign kif.key_valid = valid_q;
    assign kif.key_down  = down_q;
endmodule
